// File: rtl/microarch_trace_encoder_pkg.sv
// Shared types and record-layout helpers for the pipeline trace encoder.
// A record is packed LSB first: per-stage {pc,evt}, drop count, OVF, WRAP, timestamp.
package microarchtrace_pkg;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MSTART = 2'd2,
        MEND   = 2'd3
    } evt_e;

    localparam int EVT_W     = 2;
    localparam int FLAG_OVF  = 0;
    localparam int FLAG_WRAP = 1;
    localparam int FLAG_W    = 2;

    function automatic int stage_w(input int pc_w);
        return pc_w + EVT_W;
    endfunction

    function automatic int stage_off(input int i, input int pc_w);
        return i * stage_w(pc_w);
    endfunction

    function automatic int drop_off(input int n, input int pc_w);
        return n * stage_w(pc_w);
    endfunction

    function automatic int flag_off(input int n, input int pc_w, input int drop_w);
        return drop_off(n, pc_w) + drop_w;
    endfunction

    function automatic int ts_off(input int n, input int pc_w, input int drop_w);
        return flag_off(n, pc_w, drop_w) + FLAG_W;
    endfunction

    function automatic int rec_w(input int n, input int pc_w, input int ts_w, input int drop_w);
        return ts_off(n, pc_w, drop_w) + ts_w;
    endfunction

endpackage

// File: rtl/microarch_trace_encoder_fifo.sv
// First-word fall-through FIFO with registered storage; an extra pointer bit
// separates full from empty. Storage is not reset, only the pointers.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      fill
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fill     = wr_ptr - rd_ptr;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // A push into a full FIFO lands in the slot being vacated by the same-cycle pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/microarch_trace_encoder.sv
// Classifies per-stage busy/done activity into trace events, timestamps them and
// queues one record per active cycle, counting records lost to a full buffer.
module microarch_trace_encoder
    import microarchtrace_pkg::*;
#(
    parameter int N_STAGES = 2,
    parameter int PC_W     = 32,
    parameter int TS_W     = 16,
    parameter int DROP_W   = 8,
    parameter int DEPTH    = 16,
    localparam int REC_W   = rec_w(N_STAGES, PC_W, TS_W, DROP_W),
    localparam int FILL_W  = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [N_STAGES-1:0]      stage_busy,
    input  logic [N_STAGES-1:0]      stage_done,
    input  logic [N_STAGES*PC_W-1:0] stage_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [REC_W-1:0]         out_data,
    output logic [FILL_W-1:0]        fill,
    output logic                     overflow
);

    localparam int DROP_OFF = drop_off(N_STAGES, PC_W);
    localparam int FLAG_OFF = flag_off(N_STAGES, PC_W, DROP_W);
    localparam int TS_OFF   = ts_off(N_STAGES, PC_W, DROP_W);

    logic [TS_W-1:0]     ts;
    logic                wrap;
    logic [N_STAGES-1:0] in_multi;
    logic [N_STAGES-1:0] in_multi_nxt;
    evt_e                evt [N_STAGES];
    logic                any_evt;
    logic [DROP_W-1:0]   drop_cnt;
    logic                overflow_q;
    logic [REC_W-1:0]    rec;
    logic                push_req;
    logic                push_ok;
    logic                pop;
    logic                full;
    logic                empty;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == {DROP_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Classification keeps running while en is low so multicycle spans stay coherent.
    always_comb begin
        in_multi_nxt = in_multi;
        any_evt      = 1'b0;
        for (int i = 0; i < N_STAGES; i++) begin
            evt[i] = NONE;
            if (stage_busy[i] && stage_done[i]) begin
                evt[i]          = in_multi[i] ? MEND : SINGLE;
                in_multi_nxt[i] = 1'b0;
            end else if (stage_busy[i]) begin
                evt[i]          = in_multi[i] ? NONE : MSTART;
                in_multi_nxt[i] = 1'b1;
            end else begin
                in_multi_nxt[i] = 1'b0;
            end
            any_evt = any_evt | (evt[i] != NONE);
        end
    end

    always_comb begin
        rec = '0;
        for (int i = 0; i < N_STAGES; i++) begin
            rec[stage_off(i, PC_W) +: EVT_W]        = evt[i];
            rec[stage_off(i, PC_W) + EVT_W +: PC_W] = stage_pc[i*PC_W +: PC_W];
        end
        rec[DROP_OFF +: DROP_W]        = drop_cnt;
        rec[FLAG_OFF + FLAG_OVF]       = (drop_cnt != '0);
        rec[FLAG_OFF + FLAG_WRAP]      = wrap;
        rec[TS_OFF +: TS_W]            = ts;
    end

    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign push_req  = en & (any_evt | wrap);
    assign push_ok   = push_req & (~full | pop);
    assign overflow  = overflow_q;

    // wrap marks the cycle whose timestamp has just rolled over to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts         <= '0;
            wrap       <= 1'b0;
            in_multi   <= '0;
            drop_cnt   <= '0;
            overflow_q <= 1'b0;
        end else begin
            ts       <= ts + 1'b1;
            wrap     <= (ts == {TS_W{1'b1}});
            in_multi <= in_multi_nxt;
            if (push_ok) begin
                drop_cnt <= '0;
            end else if (push_req) begin
                drop_cnt   <= sat_inc(drop_cnt);
                overflow_q <= 1'b1;
            end
        end
    end

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_ok),
        .push_data (rec),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (full),
        .empty     (empty),
        .fill      (fill)
    );

endmodule

// File: tb/tb_microarch_trace_encoder.sv
// Directed and randomized bench for the trace encoder, checked against a
// queue-based reference model of the record stream.
module tb_microarch_trace_encoder;

    localparam int N  = 2;
    localparam int PW = 16;
    localparam int TW = 4;
    localparam int DW = 3;
    localparam int D  = 4;
    localparam int RW = TW + 2 + DW + N*(2+PW);

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [N-1:0]  busy;
    logic [N-1:0]  done;
    logic [N*PW-1:0] pc;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_data;
    logic [2:0]    fill;
    logic          overflow;

    int vectors     = 0;
    int miscompares = 0;

    logic [RW-1:0] q[$];
    int ts_m, cyc, dropm;
    bit ovfm;
    bit multi [N];

    microarch_trace_encoder #(
        .N_STAGES (N),
        .PC_W     (PW),
        .TS_W     (TW),
        .DROP_W   (DW),
        .DEPTH    (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .stage_busy (busy),
        .stage_done (done),
        .stage_pc   (pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fill       (fill),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: model the cycle from the driven inputs, advance, then compare.
    task automatic tick();
        bit pop, wrap, anye, req;
        logic [1:0] e [N];
        logic [RW-1:0] r;
        if (rst) begin
            @(posedge clk);
            #1;
            q.delete();
            ts_m = 0; cyc = 0; dropm = 0; ovfm = 0;
            for (int i = 0; i < N; i++) multi[i] = 0;
        end else begin
            pop  = (q.size() > 0) && out_ready;
            wrap = (cyc > 0) && (ts_m == 0);
            anye = 0;
            for (int i = 0; i < N; i++) begin
                if (busy[i] && done[i]) begin
                    e[i] = multi[i] ? 2'd3 : 2'd1;
                    multi[i] = 0;
                end else if (busy[i]) begin
                    e[i] = multi[i] ? 2'd0 : 2'd2;
                    multi[i] = 1;
                end else begin
                    e[i] = 2'd0;
                    multi[i] = 0;
                end
                anye = anye || (e[i] != 2'd0);
            end
            req = en && (anye || wrap);
            r = {4'(ts_m), wrap, (dropm != 0), 3'(dropm), pc[31:16], e[1], pc[15:0], e[0]};
            @(posedge clk);
            #1;
            if (pop) void'(q.pop_front());
            if (req) begin
                if (q.size() < D) begin
                    q.push_back(r);
                    dropm = 0;
                end else begin
                    ovfm = 1;
                    if (dropm < 7) dropm++;
                end
            end
            ts_m = (ts_m + 1) % 16;
            cyc++;
        end
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        check("fill", 64'(fill), 64'(q.size()));
        check("overflow", 64'(overflow), 64'(ovfm));
        if (q.size() != 0) check("out_data", 64'(out_data), 64'(q[0]));
    endtask

    task automatic drive(input logic [1:0] b, input logic [1:0] d, input logic e_n, input logic rdy);
        busy = b; done = d; en = e_n; out_ready = rdy;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; busy = '0; done = '0; pc = '0; out_ready = 1'b1;
        tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_fill", 64'(fill), 64'd0);
        rst = 1'b0;

        // single event at ts=5, visible the following cycle
        repeat (5) tick();
        pc = {16'h0000, 16'h0080};
        drive(2'b01, 2'b01, 1'b1, 1'b1);
        tick();
        check("single_evt0", 64'(out_data[1:0]), 64'd1);
        check("single_evt1", 64'(out_data[19:18]), 64'd0);
        check("single_ts", 64'(out_data[44:41]), 64'd5);
        check("single_pc", 64'(out_data[17:2]), 64'h80);
        drive(2'b00, 2'b00, 1'b1, 1'b1);
        tick();

        // stage1 multicycle: start, two quiet cycles, end
        pc = {16'h0100, 16'h0000};
        repeat (3) begin drive(2'b10, 2'b00, 1'b1, 1'b1); tick(); end
        drive(2'b10, 2'b10, 1'b1, 1'b1);
        tick();
        check("mend_evt1", 64'(out_data[19:18]), 64'd3);

        // drain, then overflow with sink stalled
        drive(2'b00, 2'b00, 1'b0, 1'b1);
        repeat (6) tick();
        repeat (7) begin drive(2'b01, 2'b01, 1'b1, 1'b0); tick(); end
        check("ovf_fill", 64'(fill), 64'd4);
        check("ovf_sticky", 64'(overflow), 64'd1);
        repeat (6) begin drive(2'b01, 2'b01, 1'b1, 1'b1); tick(); end

        // full FIFO with same-cycle pop and push
        repeat (5) begin drive(2'b01, 2'b01, 1'b1, 1'b0); tick(); end
        drive(2'b00, 2'b00, 1'b1, 1'b0); tick();
        drive(2'b00, 2'b00, 1'b0, 1'b1); repeat (6) tick();
        repeat (4) begin drive(2'b01, 2'b01, 1'b1, 1'b0); tick(); end
        drive(2'b01, 2'b01, 1'b1, 1'b1);
        tick();
        check("fullpop_fill", 64'(fill), 64'd4);

        // drop counter saturation
        repeat (12) begin drive(2'b01, 2'b01, 1'b1, 1'b0); tick(); end
        repeat (8) begin drive(2'b01, 2'b01, 1'b1, 1'b1); tick(); end

        // idle wrap records
        drive(2'b00, 2'b00, 1'b1, 1'b1);
        repeat (34) tick();

        // MSTART while disabled still closes with MEND
        drive(2'b00, 2'b00, 1'b0, 1'b1);
        repeat (6) tick();
        repeat (2) begin drive(2'b01, 2'b00, 1'b0, 1'b1); tick(); end
        drive(2'b01, 2'b01, 1'b1, 1'b1);
        tick();
        check("en_mend", 64'(out_data[1:0]), 64'd3);

        // reset mid-operation
        drive(2'b00, 2'b00, 1'b0, 1'b1);
        repeat (6) tick();
        repeat (3) begin drive(2'b11, 2'b01, 1'b1, 1'b0); tick(); end
        check("pre_rst_fill", 64'(fill), 64'd3);
        drive(2'b10, 2'b00, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_fill", 64'(fill), 64'd0);
        rst = 1'b0;
        tick();
        check("post_rst_evt1", 64'(out_data[19:18]), 64'd2);
        check("post_rst_ts", 64'(out_data[44:41]), 64'd0);

        // randomized traffic
        for (int k = 0; k < 500; k++) begin
            busy      = 2'($urandom);
            done      = 2'($urandom);
            pc        = $urandom;
            en        = ($urandom % 8) != 0;
            out_ready = ($urandom % 3) != 0;
            if (k % 100 < 15) begin busy = '0; end
            if (k % 100 > 80) out_ready = 1'b0;
            rst = ($urandom % 150) == 0;
            tick();
            rst = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/microarch_trace_encoder.md
Name: microarch_trace_encoder

Overview:
Synthesizable, parametrised trace event encoder for core pipeline stages. It tracks N independent stages, each described by a busy/done pair plus a PC. Per stage it classifies single-cycle, multicycle-start and multicycle-end events. Each cycle's events are packed into one timestamped record, buffered in an on-chip FIFO and drained over a valid/ready stream to a trace sink (DMA, UART bridge or simulation monitor).

Parameters:
N_STAGES, 2, number of traced stages (1..8)
PC_W, 32, PC width per stage
TS_W, 16, free-running timestamp width
DROP_W, 8, saturating dropped-record counter width
DEPTH, 16, FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
en  in  1  record enable; tracking continues when low, records suppressed
stage_busy  in  N_STAGES  stage holds an instruction this cycle
stage_done  in  N_STAGES  stage completes this cycle (qualified by busy)
stage_pc  in  N_STAGES*PC_W  PC per stage, stage i at [i*PC_W +: PC_W]
out_valid  out  1  record available
out_ready  in  1  sink accepts record
out_data  out  REC_W  record, REC_W = TS_W+2+DROP_W+N_STAGES*(2+PC_W)
fill  out  $clog2(DEPTH)+1  FIFO occupancy
overflow  out  1  sticky: at least one record dropped since reset

Behaviour:
- Reset (rst=1 at posedge): ts=0, all in_multi=0, FIFO empty, out_valid=0, fill=0, overflow=0, drop_cnt=0.
- ts increments every cycle and wraps 2^TS_W-1 -> 0. Wrap cycle sets the record WRAP flag and forces a record even with no stage events.
- Per-stage event evt[1:0], with in_multi as a per-stage flag:
  - busy&done: evt = in_multi ? MEND(3) : SINGLE(1); in_multi<=0.
  - busy&!done&!in_multi: evt = MSTART(2); in_multi<=1.
  - busy&!done&in_multi: evt = NONE(0).
  - !busy: evt = NONE; in_multi<=0 (flush, no end event). done ignored when !busy.
- Record pushed when en=1 and (any evt!=NONE or WRAP).
- Record layout, LSB first: per-stage {pc,evt} for stage 0..N-1, then drop_cnt[DROP_W], OVF bit, WRAP bit, ts[TS_W] at MSBs. ts is the cycle of the event.
- Push is accepted if fill<DEPTH, or if fill==DEPTH and a pop (out_valid&out_ready) occurs the same cycle.
- Rejected push: record dropped; overflow<=1; drop_cnt increments, saturating at 2^DROP_W-1.
- Next accepted record carries OVF=1 and the current drop_cnt, then drop_cnt clears. If a record is accepted in the same cycle as a drop, the count includes that drop.
- Latency: event at cycle t is visible on out_data/out_valid at t+1 when the FIFO was empty (first-word fall-through from registered storage).
- out_data is stable while out_valid & !out_ready. Order is preserved.
- Simultaneous push and pop leaves fill unchanged. Pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit.
- Reset mid-operation discards FIFO contents and multicycle state; the first post-reset record uses ts counted from 0.

Decomposition:
- Package microarchtrace_pkg holds:
  - evt_e enum (NONE, SINGLE, MSTART, MEND)
  - localparam functions for REC_W and field offsets
  - flag bit positions
- Sub-module trace_fifo (parametrised WIDTH, DEPTH; FWFT; push/pop/full/empty/fill) holds the buffering. The encoder holds the classification, timestamp and drop logic.

Test Plan:
- N=2, stage0 busy&done at ts=5, pc=0x80 -> one record ts=5, evt0=1, evt1=0, OVF=0, out_valid at ts=6.
- Stage1 busy cycles 10..13, done at 13, pc=0x100 -> records at ts=10 (evt1=2) and ts=13 (evt1=3); no records ts=11,12.
- out_ready=0, DEPTH=4, stage0 single event every cycle for 7 cycles -> fill=4, overflow=1, drop_cnt=3. Then out_ready=1 -> next new record has OVF=1, drop=3; the following record has OVF=0, drop=0.
- Full FIFO with out_ready=1 and a push in the same cycle -> push accepted, fill stays 4, no drop.
- TS_W=4, idle run -> WRAP record at ts=0 every 16 cycles with all evt=NONE. en=0 -> no records, while an MSTART seen during en=0 still yields MEND after en rises.
- rst asserted while stage busy and FIFO holding 3 records -> next cycle out_valid=0, fill=0; continued busy then yields MSTART, not NONE.
